// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue control: launches Start/MDOp from E, tracks unit Busy,
// stalls D-stage HI/LO users while an operation is in flight, with a busy watchdog.
module md_issue_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       e_md_op,
    input  logic             e_flush,
    input  logic [2:0]       d_md_op,
    input  logic             md_busy,
    output logic             md_start,
    output logic [2:0]       md_op,
    output logic             stall_d,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned      WC_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_md_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_start_op;
    logic w_mt_op;
    logic w_inflight;
    logic w_stall_d;

    assign w_start_op = (e_md_op inside {3'd1, 3'd2, 3'd3, 3'd4}) && !e_flush;
    assign w_mt_op    = (e_md_op inside {3'd5, 3'd6}) && !e_flush;

    // Launch cycle counts as in flight: Busy only rises the cycle after Start.
    assign w_inflight = ((r_state == S_WAIT) && md_busy) ||
                        ((r_state == S_IDLE) && w_start_op);
    assign w_stall_d  = (d_md_op != 3'd0) && w_inflight;

    // Requests are only forwarded from IDLE; anything seen in WAIT is dropped.
    always_comb begin
        md_start = 1'b0;
        md_op    = 3'd0;
        if (r_state == S_IDLE) begin
            md_start = w_start_op;
            md_op    = (w_start_op || w_mt_op) ? e_md_op : 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_md_err    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_op) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (!md_busy) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                        // Watchdog fails open so the pipeline cannot deadlock.
                        if (r_wait_cnt == WC_LAST) begin
                            r_md_err <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_stall_d && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_d   = w_stall_d;
    assign md_err    = r_md_err;
    assign stall_cnt = r_stall_cnt;

endmodule
